// File: rtl/noc2aximst_burst_gen_if.sv
// Command and AXI address-channel bundle between the NoC request decoder,
// the burst generator and the AR/AW channel mux.
interface noc2aximst_burst_gen_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_beats;
  logic [2:0]        cmd_prot;

  logic              ax_valid;
  logic              ax_ready;
  logic              ax_write;
  logic [ADDR_W-1:0] ax_addr;
  logic [7:0]        ax_len;
  logic [2:0]        ax_size;
  logic [1:0]        ax_burst;
  logic [2:0]        ax_prot;
  logic              ax_last;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_prot, ax_ready,
    output cmd_ready, ax_valid, ax_write, ax_addr, ax_len, ax_size, ax_burst,
           ax_prot, ax_last
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_prot, ax_ready,
    input  cmd_ready, ax_valid, ax_write, ax_addr, ax_len, ax_size, ax_burst,
           ax_prot, ax_last
  );
endinterface

// File: rtl/noc2aximst_burst_gen.sv
// Splits one DMA transfer command into legal AXI INCR address bursts (capped at
// MAX_BURST beats, never crossing BOUNDARY) and tracks outstanding bursts.
module noc2aximst_burst_gen #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 256,
  parameter int BOUNDARY  = 4096,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  noc2aximst_burst_gen_if.master         bus,
  input  logic                           cpl_valid,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst,
  output logic                           done,
  output logic                           cpl_err
);

  localparam int SIZE = $clog2(DATA_W/8);
  localparam int OW   = $clog2(MAX_OUTST+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CPL} state_t;

  state_t            state;
  logic [LEN_W-1:0]  rem;
  logic [OW-1:0]     outst_next;
  logic              issue;
  logic              cpl_ok;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [8:0]        start_n;
  logic [8:0]        next_n;

  // Beats in the burst starting at addr: limited by what is left, the cap and the boundary.
  function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] addr,
                                             input logic [LEN_W-1:0]  left);
    logic [63:0] room;
    logic [63:0] n;
    room = (64'(BOUNDARY) - (64'(addr) % 64'(BOUNDARY))) >> SIZE;
    n    = 64'(left);
    if (n > 64'(MAX_BURST)) n = 64'(MAX_BURST);
    if (n > room) n = room;
    return n[8:0];
  endfunction

  assign issue      = bus.ax_valid && bus.ax_ready;
  assign cpl_ok     = cpl_valid && (outst != '0);
  assign start_addr = bus.cmd_addr & ~ADDR_W'(DATA_W/8 - 1);
  assign start_n    = burst_beats(start_addr, bus.cmd_beats);
  assign next_addr  = bus.ax_addr + (ADDR_W'({1'b0, bus.ax_len} + 9'd1) << SIZE);
  assign next_n     = burst_beats(next_addr, rem);

  assign bus.ax_size  = 3'(SIZE);
  assign bus.ax_burst = 2'b01;

  always_comb begin
    outst_next = outst;
    if (issue && !cpl_ok)
      outst_next = outst + OW'(1);
    else if (!issue && cpl_ok)
      outst_next = outst - OW'(1);
  end

  // rem holds the beats still to be issued after the burst currently on the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rem           <= '0;
      outst         <= '0;
      done          <= 1'b0;
      cpl_err       <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.ax_valid  <= 1'b0;
      bus.ax_write  <= 1'b0;
      bus.ax_addr   <= '0;
      bus.ax_len    <= '0;
      bus.ax_prot   <= '0;
      bus.ax_last   <= 1'b0;
    end else begin
      done  <= 1'b0;
      outst <= outst_next;
      if (cpl_valid && outst == '0)
        cpl_err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            bus.ax_write  <= bus.cmd_write;
            bus.ax_prot   <= bus.cmd_prot;
            if (bus.cmd_beats == '0) begin
              state <= WAIT_CPL;
            end else begin
              state        <= ISSUE;
              bus.ax_valid <= (outst_next < OW'(MAX_OUTST));
              bus.ax_addr  <= start_addr;
              bus.ax_len   <= 8'(start_n - 9'd1);
              bus.ax_last  <= (LEN_W'(start_n) == bus.cmd_beats);
              rem          <= bus.cmd_beats - LEN_W'(start_n);
            end
          end
        end

        ISSUE: begin
          if (issue && bus.ax_last) begin
            state        <= WAIT_CPL;
            bus.ax_valid <= 1'b0;
          end else begin
            bus.ax_valid <= (outst_next < OW'(MAX_OUTST));
            if (issue) begin
              bus.ax_addr <= next_addr;
              bus.ax_len  <= 8'(next_n - 9'd1);
              bus.ax_last <= (LEN_W'(next_n) == rem);
              rem         <= rem - LEN_W'(next_n);
            end
          end
        end

        WAIT_CPL: begin
          if (outst_next == '0) begin
            done          <= 1'b1;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc2aximst_burst_gen.sv
// Self-checking bench for noc2aximst_burst_gen: directed scenarios plus random
// commands compared against a burst-list reference model.
module tb_noc2aximst_burst_gen;

  localparam int MAX_OUTST = 2;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } burst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpl_valid = 1'b0;
  logic [1:0] outst;
  logic       done;
  logic       cpl_err;
  int         checks = 0;
  int         failures = 0;
  burst_t     exp_q[$];

  noc2aximst_burst_gen_if #(.ADDR_W(32), .LEN_W(16)) bus ();

  noc2aximst_burst_gen #(
    .ADDR_W(32), .DATA_W(64), .LEN_W(16), .MAX_BURST(256),
    .BOUNDARY(4096), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cpl_valid(cpl_valid),
    .outst(outst), .done(done), .cpl_err(cpl_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected bursts: 8-byte beats, 256-beat cap, 4 KB boundary, 32-bit wrap.
  function automatic void build_model(input logic [31:0] addr, input int beats);
    longint a, rem, n, room;
    exp_q.delete();
    a   = longint'(addr & 32'hFFFF_FFF8);
    rem = beats;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 8;
      n = rem;
      if (n > 256) n = 256;
      if (n > room) n = room;
      exp_q.push_back('{addr: a[31:0], len: 8'(n - 1), last: (n == rem)});
      a   = (a + n * 8) % 64'h1_0000_0000;
      rem = rem - n;
    end
  endfunction

  task automatic accept(input logic [31:0] addr, input int beats, input logic wr,
                        input logic [2:0] prot);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_ready got=%b exp=1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_beats = 16'(beats);
    bus.cmd_write = wr;
    bus.cmd_prot  = prot;
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cmd_ready_busy got=%b exp=0", bus.cmd_ready);
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int beats, input logic wr,
                         input logic [2:0] prot, input int stall, input int ready_pct,
                         input int cpl_pct, input string tag);
    int     m_outst = 0;
    int     cyc = 0;
    logic   rdy, cpl;
    burst_t e;
    build_model(addr, beats);
    accept(addr, beats, wr, prot);
    while ((exp_q.size() > 0 || m_outst > 0) && cyc < 5000) begin
      checks++;
      if (outst !== 2'(m_outst)) begin
        failures++;
        $display("[TB] FAIL %s outst got=%0d exp=%0d", tag, outst, m_outst);
      end
      checks++;
      if (bus.ax_valid !== (exp_q.size() > 0 && m_outst < MAX_OUTST)) begin
        failures++;
        $display("[TB] FAIL %s ax_valid got=%b exp=%b", tag, bus.ax_valid,
                 (exp_q.size() > 0 && m_outst < MAX_OUTST));
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s early_done got=%b exp=0", tag, done);
      end
      if (bus.ax_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q[0];
        checks++;
        if (bus.ax_addr !== e.addr || bus.ax_len !== e.len || bus.ax_last !== e.last ||
            bus.ax_write !== wr || bus.ax_prot !== prot || bus.ax_size !== 3'd3 ||
            bus.ax_burst !== 2'b01) begin
          failures++;
          $display("[TB] FAIL %s burst got=(%h,%0d,%b,%b,%0d,%0d,%0d) exp=(%h,%0d,%b,%b,%0d,3,1)",
                   tag, bus.ax_addr, bus.ax_len, bus.ax_last, bus.ax_write, bus.ax_prot,
                   bus.ax_size, bus.ax_burst, e.addr, e.len, e.last, wr, prot);
        end
      end
      rdy = (cyc < stall) ? 1'b0 : ($urandom_range(99) < 32'(ready_pct));
      cpl = (m_outst > 0) && ($urandom_range(99) < 32'(cpl_pct));
      bus.ax_ready = rdy;
      cpl_valid    = cpl;
      if (cpl) m_outst--;
      if (bus.ax_valid === 1'b1 && rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_outst++;
      end
      step();
      cyc++;
    end
    bus.ax_ready = 1'b0;
    cpl_valid    = 1'b0;
    checks++;
    if (cyc >= 5000) begin
      failures++;
      $display("[TB] FAIL %s timeout got=%0d_cycles exp=<5000", tag, cyc);
    end
    checks++;
    if (done !== 1'b1 || bus.cmd_ready !== 1'b1 || outst !== 2'd0) begin
      failures++;
      $display("[TB] FAIL %s completion got=done%b/ready%b/outst%0d exp=1/1/0",
               tag, done, bus.cmd_ready, outst);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s done_pulse got=%b exp=0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.ax_valid !== 1'b0 || outst !== 2'd0 ||
        done !== 1'b0 || cpl_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b%b%0d%b%b exp=10000",
               bus.cmd_ready, bus.ax_valid, outst, done, cpl_err);
    end
    checks++;
    if (bus.ax_addr !== 32'h0 || bus.ax_len !== 8'h0 || bus.ax_burst !== 2'b01 ||
        bus.ax_size !== 3'd3 || bus.ax_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_fields got=%h/%0d/%0d/%0d/%b exp=0/0/1/3/0",
               bus.ax_addr, bus.ax_len, bus.ax_burst, bus.ax_size, bus.ax_last);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    run_cmd(32'h1000, 8, 1'b1, 3'b010, 0, 100, 100, "single");
  endtask

  task automatic test_split_max();
    run_cmd(32'h0, 300, 1'b0, 3'b000, 0, 100, 50, "split_max");
  endtask

  task automatic test_boundary();
    run_cmd(32'hFF0, 8, 1'b1, 3'b101, 0, 100, 50, "boundary");
  endtask

  task automatic test_stall();
    run_cmd($urandom() & 32'h0000_FFF8, 40, 1'b0, 3'b011, 5, 100, 50, "stall");
  endtask

  task automatic test_outstanding();
    build_model(32'h0, 1024);
    accept(32'h0, 1024, 1'b1, 3'b000);
    bus.ax_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.ax_valid !== 1'b1 || bus.ax_addr !== exp_q[i].addr || outst !== 2'(i)) begin
        failures++;
        $display("[TB] FAIL outst_issue%0d got=%b/%h/%0d exp=1/%h/%0d",
                 i, bus.ax_valid, bus.ax_addr, outst, exp_q[i].addr, i);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.ax_valid !== 1'b0 || outst !== 2'd2) begin
        failures++;
        $display("[TB] FAIL outst_full got=%b/%0d exp=0/2", bus.ax_valid, outst);
      end
      step();
    end
    cpl_valid = 1'b1;
    bus.ax_ready = 1'b0;
    step();
    checks++;
    if (bus.ax_valid !== 1'b1 || outst !== 2'd1 || bus.ax_addr !== exp_q[2].addr) begin
      failures++;
      $display("[TB] FAIL outst_resume got=%b/%0d/%h exp=1/1/%h",
               bus.ax_valid, outst, bus.ax_addr, exp_q[2].addr);
    end
    bus.ax_ready = 1'b1;
    step();
    cpl_valid = 1'b0;
    checks++;
    if (outst !== 2'd1 || bus.ax_valid !== 1'b1 || bus.ax_addr !== exp_q[3].addr ||
        bus.ax_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL outst_coincide got=%0d/%b/%h/%b exp=1/1/%h/1",
               outst, bus.ax_valid, bus.ax_addr, bus.ax_last, exp_q[3].addr);
    end
    step();
    bus.ax_ready = 1'b0;
    checks++;
    if (outst !== 2'd2 || bus.ax_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL outst_last got=%0d/%b/%b exp=2/0/0", outst, bus.ax_valid, done);
    end
    cpl_valid = 1'b1;
    step();
    step();
    cpl_valid = 1'b0;
    checks++;
    if (outst !== 2'd0 || done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL outst_done got=%0d/%b/%b exp=0/1/1", outst, done, bus.cmd_ready);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_cmd($urandom(), int'($urandom_range(600, 1)), 1'($urandom_range(1, 0)),
              3'($urandom_range(7, 0)), 0, 70, 40, "random");
  endtask

  task automatic test_cpl_err();
    checks++;
    if (cpl_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cpl_err_clear got=%b exp=0", cpl_err);
    end
    cpl_valid = 1'b1;
    step();
    cpl_valid = 1'b0;
    checks++;
    if (cpl_err !== 1'b1 || outst !== 2'd0) begin
      failures++;
      $display("[TB] FAIL cpl_err_set got=%b/%0d exp=1/0", cpl_err, outst);
    end
    run_cmd(32'h2000, 4, 1'b0, 3'b000, 0, 100, 100, "after_err");
    checks++;
    if (cpl_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cpl_err_sticky got=%b exp=1", cpl_err);
    end
  endtask

  task automatic test_reset_mid();
    accept(32'h0, 300, 1'b0, 3'b000);
    bus.ax_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.ax_ready = 1'b0;
    step();
    checks++;
    if (bus.ax_valid !== 1'b0 || outst !== 2'd0 || cpl_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid got=%b/%0d/%b exp=0/0/0", bus.ax_valid, outst, cpl_err);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.ax_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b/%b/%b exp=1/0/0", bus.cmd_ready, bus.ax_valid, done);
    end
  endtask

  task automatic test_zero_beat();
    accept(32'h3000, 0, 1'b1, 3'b000);
    checks++;
    if (done !== 1'b0 || bus.ax_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_first got=%b/%b exp=0/0", done, bus.ax_valid);
    end
    step();
    checks++;
    if (done !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.ax_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_done got=%b/%b/%b exp=1/1/0", done, bus.cmd_ready, bus.ax_valid);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_pulse got=%b exp=0", done);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    bus.cmd_prot  = '0;
    bus.ax_ready  = 1'b0;
    test_reset();
    test_single();
    test_split_max();
    test_boundary();
    test_stall();
    test_outstanding();
    test_random();
    test_cpl_err();
    test_reset_mid();
    test_zero_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc2aximst_burst_gen.md
# noc2aximst_burst_gen

Parametrised AXI burst generator for the NoC-to-AXI-master proxy. It accepts one transfer command per DMA NoC request: start address, beat count and direction. It emits a sequence of legal AXI INCR address-channel bursts, splitting each command at `MAX_BURST` beats and at `BOUNDARY`-byte address boundaries. It also tracks outstanding bursts against a configurable limit. It sits between the NoC request decoder and the AR/AW channel muxing of the AXI master port, and generalises the fixed-width, single-burst address path to arbitrary data width, burst cap and outstanding depth.

## Interface
- `ADDR_W`, default 32: address width (`GLOB_PHYS_ADDR_BITS`).
- `DATA_W`, default 64: AXI data width in bits; power of two, 8..1024.
- `LEN_W`, default 16: width of the command beat count.
- `MAX_BURST`, default 256: maximum beats per AXI burst; power of two, 1..256.
- `BOUNDARY`, default 4096: byte boundary that no burst may cross; power of two.
- `MAX_OUTST`, default 4: maximum bursts issued but not completed; ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write (AW), 0 = read (AR).
- `cmd_addr`  in  `ADDR_W`  start byte address.
- `cmd_beats`  in  `LEN_W`  total beats.
- `cmd_prot`  in  3  AXI prot passed to every burst.
- `ax_valid`  out  1  address beat valid.
- `ax_ready`  in  1  address beat accepted.
- `ax_write`, `ax_addr[ADDR_W]`, `ax_len[8]`, `ax_size[3]`, `ax_burst[2]`, `ax_prot[3]`  out  burst fields.
- `ax_last`  out  1  this burst is the final one of the command.
- `cpl_valid`  in  1  one burst completed: R last beat or B handshake.
- `outst`  out  `$clog2(MAX_OUTST+1)`  current outstanding count.
- `done`  out  1  one-cycle pulse when a command is fully completed.
- `cpl_err`  out  1  sticky flag: completion arrived with `outst` == 0.

## Operation
- `ax_size` is constant: `$clog2(DATA_W/8)`. `ax_burst` is INCR (2'b01).
- FSM states: `IDLE`, `ISSUE`, `WAIT_CPL`.
- `IDLE`:
  - `cmd_ready` = 1.
  - On handshake, register the address with its low `$clog2(DATA_W/8)` bits forced to 0, plus beats, write and prot.
  - If `cmd_beats` == 0, go to `WAIT_CPL`; otherwise go to `ISSUE`.
- `ISSUE`:
  - Burst beats `n` = min(remaining, `MAX_BURST`, (`BOUNDARY` − addr mod `BOUNDARY`) >> size).
  - `ax_len` = n − 1. `ax_last` = (n == remaining).
  - `ax_valid` = (`outst` < `MAX_OUTST`).
  - On `ax_valid && ax_ready`: addr += n << size, remaining −= n, `outst` += 1.
  - If `ax_last` was set, go to `WAIT_CPL`.
- `WAIT_CPL`: when `outst` == 0, pulse `done` for one cycle and go to `IDLE`.
- `outst` bookkeeping:
  - A burst issued and `cpl_valid` in the same cycle leave `outst` unchanged.
  - `cpl_valid` with `outst` == 0 is ignored and sets `cpl_err`, which is cleared only by reset.
- The next command is accepted only after `done`. There is one command in flight at a time.
- Address arithmetic is `ADDR_W` bits wide and wraps at 2^`ADDR_W`. The boundary rule guarantees that no single burst wraps.

## Timing
- Reset values:
  - state `IDLE`, `cmd_ready` = 1 once out of reset.
  - `ax_valid` = 0, `ax_*` fields = 0 (`ax_burst` = 2'b01, `ax_size` constant).
  - `outst` = 0, `done` = 0, `cpl_err` = 0.
- Command accepted at edge k → `ax_valid` high in cycle k+1. All `ax_*` fields are registered.
- While `ax_valid && !ax_ready`, every `ax_*` field holds stable. `ax_valid` never drops without a handshake, except through reset.
- Back-to-back bursts: after a handshake at edge j, the next burst is presented in cycle j+1. The sustained rate is one burst per cycle.
- If `outst` reaches `MAX_OUTST` at the handshake, `ax_valid` is 0 from the next cycle. It reasserts the cycle after a `cpl_valid`.
- `done` fires the cycle after the final completion. `cmd_ready` rises in the same cycle as `done`.
- Zero-beat command: `done` two cycles after acceptance; no AXI activity.
- Reset asserted mid-command: all state is discarded on the next edge. In-flight AXI completions after reset are the wrapper's concern and count toward `cpl_err`.

## Test plan
- DATA_W=64, addr 0x1000, 8 beats, `ax_ready`=1 → one burst: addr 0x1000, len 7, size 3, `ax_last`=1; `cpl_valid` → `done` next cycle.
- addr 0x0, 300 beats → bursts (0x0, len 255) then (0x800, len 43, last).
- addr 0xFF0, 8 beats → bursts (0xFF0, len 1) then (0x1000, len 5); the 4 KB boundary is not crossed.
- MAX_OUTST=2, 1024 beats, no completions → exactly 2 bursts, then `ax_valid` stays 0. One `cpl_valid` → the third burst appears the next cycle. A completion coinciding with an issue leaves `outst` unchanged.
- `ax_ready` held low 5 cycles → fields stable. `cpl_valid` while idle → `cpl_err`=1, sticky.
- `rst` low mid-burst → next cycle `ax_valid`=0, `outst`=0, `cmd_ready`=1 after release. A zero-beat command → `done` with no `ax_valid`.
